// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory port, redirect input, decode handshake
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [DATA_WIDTH-1:0] inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc_plus4;

  // Fetch stage side
  modport master (
    output inst_addr,
    input  inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output out_pc_plus4
  );

  // Memory / control / decode side
  modport slave (
    input  inst_addr,
    output inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  out_pc_plus4
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, instruction fetch and 2-entry fetch buffer with redirect flush
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [1:0]            r_cnt;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [ADDR_WIDTH-1:0] r_buf_pc   [2];
  logic [DATA_WIDTH-1:0] r_buf_inst [2];

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_head_pc;

  assign w_valid   = (r_cnt != 2'd0);
  assign w_pop     = w_valid && bus.out_ready;
  // A pop frees a slot in the same edge, so a full buffer can still accept a new fetch.
  assign w_push    = !bus.redirect_valid && ((r_cnt != 2'd2) || w_pop);
  // Low two bits of the target are dropped to keep every fetch word-aligned.
  assign w_target  = bus.redirect_pc & ~ADDR_WIDTH'(3);
  assign w_head_pc = r_buf_pc[r_rptr];

  // PC, occupancy and pointers; a redirect overrides pop and push and flushes the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc   <= w_target;
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push) begin
        r_wptr <= ~r_wptr;
        r_pc   <= r_pc + ADDR_WIDTH'(4);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Buffer storage is data only; its contents are meaningless whenever the count says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wptr]   <= r_pc;
      r_buf_inst[r_wptr] <= bus.inst;
    end
  end

  assign bus.inst_addr    = r_pc;
  assign bus.out_valid    = w_valid;
  assign bus.out_pc       = w_head_pc;
  assign bus.out_inst     = r_buf_inst[r_rptr];
  assign bus.out_pc_plus4 = w_head_pc + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  function automatic logic [31:0] mem(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  always_comb bus1.inst = mem(bus1.inst_addr);
  always_comb bus2.inst = mem(bus2.inst_addr);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, inst} plus the next fetch address
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;

  task automatic model_reset(input logic [31:0] rpc);
    m_q.delete();
    m_pc = rpc;
  endtask

  // Apply inputs for one cycle (called at a negedge), advance the model, land on the next negedge
  task automatic step(input logic redir, input logic [31:0] rpc, input logic ready);
    int     n;
    logic   pop;
    entry_t e;
    bus1.redirect_valid = redir;
    bus1.redirect_pc    = rpc;
    bus1.out_ready      = ready;
    @(posedge clk);
    n   = m_q.size();
    pop = (n != 0) && ready;
    if (redir) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (n < 2 || pop) begin
        e.pc   = m_pc;
        e.inst = mem(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'd0, bus1.out_valid}, {31'd0, m_q.size() != 0});
    chk({tag, ".addr"}, bus1.inst_addr, m_pc);
    if (m_q.size() != 0) begin
      chk({tag, ".pc"}, bus1.out_pc, m_q[0].pc);
      chk({tag, ".inst"}, bus1.out_inst, m_q[0].inst);
      chk({tag, ".pc4"}, bus1.out_pc_plus4, m_q[0].pc + 32'd4);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 32'h1000_0000, 32'h004};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 32'h1000_0001, 32'h008};
    vecs[2] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 32'h1000_0001, 32'h00C};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 32'h1000_0001, 32'h00C};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 32'h1000_0002, 32'h010};
    vecs[5] = '{1'b1, 32'h103, 1'b1, 1'b0, 32'h000, 32'h0000_0000, 32'h100};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h1000_0040, 32'h104};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 32'h1000_0041, 32'h108};
    vecs[8] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 32'h1000_0041, 32'h10C};

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    bus1.out_ready      = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.out_ready      = 1'b1;
    model_reset(32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("reset.valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("reset.addr", bus1.inst_addr, 32'h0);

    // Directed table: stream, backpressure, redirect while full with a same-cycle pop
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      chk($sformatf("vec%0d.valid", i), {31'd0, bus1.out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.addr", i), bus1.inst_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d.pc", i), bus1.out_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d.inst", i), bus1.out_inst, vecs[i].exp_inst);
        chk($sformatf("vec%0d.pc4", i), bus1.out_pc_plus4, vecs[i].exp_pc + 32'd4);
      end
    end

    // Async reset mid-cycle with a full buffer
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async.valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("async.addr", bus1.inst_addr, 32'h0);
    model_reset(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_model("restart");

    // Backpressure from cycle 1 for five cycles, then drain
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, i == 0);
    chk("bp.addr", bus1.inst_addr, 32'h8);
    chk("bp.head", bus1.out_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d.pc", i), bus1.out_pc, 32'(i * 4));
      step(1'b0, 32'h0, 1'b1);
    end
    check_model("drained");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 9) < 7);
      check_model("rand");
    end

    // PC wrap on the second instance
    rst2_n = 1'b1;
    chk("wrap.reset_valid", {31'd0, bus2.out_valid}, 32'd0);
    chk("wrap.reset_addr", bus2.inst_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap.pc0", bus2.out_pc, 32'hFFFF_FFF8);
    chk("wrap.inst0", bus2.out_inst, mem(32'hFFFF_FFF8));
    @(negedge clk);
    chk("wrap.pc1", bus2.out_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4_1", bus2.out_pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap.pc2", bus2.out_pc, 32'h0);
    chk("wrap.inst2", bus2.out_inst, 32'h1000_0000);
    chk("wrap.valid2", {31'd0, bus2.out_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
